phy_rx_link_ctrl: RTL and testbench
===================================

Name: phy_rx_link_ctrl

Overview:
Link-bring-up controller for the two-lane PHY receive path. It watches the byte stream from each lane's serial-to-parallel deframer and runs a per-lane lock FSM that hunts for COM characters. A global link FSM raises link_up and enables the 8-to-32 converters and unstripe only when every lane is locked. It tears the link down on any lane loss or on a retrain request, and it counts lock-loss events for status.

Parameters:
NUM_LANES, 2, number of receive lanes; fixed at 2 for this revision.
COM, 8'hBC, comma/alignment character.
IDL, 8'h7C, idle character; legal only while locked.
SYNC_COUNT, 4, consecutive COM bytes needed to lock a lane (range 1..15).
LOSS_LIMIT, 3, consecutive non-COM/non-IDL/non-data error strobes before a locked lane unlocks (range 1..15).

Ports:
clk  in  1  single clock; all state updates on rising edge.
reset  in  1  synchronous, active-high.
retrain  in  1  level; while high, forces all lanes and the link to the unlocked state.
lane_byte  in  16  {lane1[15:8], lane0[7:0]} deframer bytes.
lane_stb  in  2  per-lane one-cycle strobe; lane_byte slice is valid when its bit is high.
lane_err  in  2  per-lane code-violation flag; sampled only with lane_stb.
lane_locked  out  2  per-lane lock status.
link_up  out  1  all lanes locked and link FSM in UP.
path_en  out  1  enable to conv8_32/unstripe; equals link_up.
data_stb  out  2  per-lane strobe for payload bytes (locked, not COM/IDL, no error).
data_byte  out  16  lane_byte registered one cycle.
loss_cnt  out  8  saturating count of lane lock-loss events.

Behaviour:
- All outputs are registered, with 1-cycle latency from the input strobe. Reset values: lane_locked=0, link_up=0, path_en=0, data_stb=0, data_byte=0, loss_cnt=0.
- Per-lane FSM (state advances only on that lane's strobe, except retrain/reset):
  - HUNT: on strobe with COM and no err, sync_cnt+1; any other strobe clears sync_cnt. Reaching SYNC_COUNT -> LOCKED and clears sync_cnt. Locking takes effect on the cycle of the SYNC_COUNT-th COM; lane_locked rises the next cycle.
  - LOCKED: COM, IDL and error-free data clear err_cnt. lane_err strobe increments err_cnt. Reaching LOSS_LIMIT -> HUNT, with err_cnt=0 and a loss event.
  - Non-error strobes break the error run; errors must be consecutive.
- data_stb[i] = registered (lane_stb[i] & LOCKED_i & !lane_err[i] & byte!=COM & byte!=IDL). The byte that completes lock is COM, so it never produces data_stb.
- Link FSM:
  - DOWN: when all lanes are LOCKED -> UP. link_up and path_en rise the cycle after the last lane's lane_locked rises.
  - UP: any lane leaving LOCKED -> DOWN. link_up falls in the same cycle that lane_locked falls.
- loss_cnt: +1 per lane loss event. If both lanes lose in the same cycle, +2. Saturates at 255; never wraps.
- retrain: lanes go to HUNT, counters clear, link goes to DOWN, outputs drop on the next edge. Does not count as a loss. Lanes stay in HUNT while retrain is high, and strobes are ignored.
- reset overrides retrain. Reset mid-lock returns everything to reset values, including loss_cnt; retrain leaves loss_cnt intact.
- Strobes without lane_locked still update data_byte; data_byte is don't-care when data_stb=0.

Test Plan:
- Reset then 4 COM strobes on lane0 only -> lane_locked=01 after the 4th strobe, link_up stays 0; 4 COM on lane1 -> lane_locked=11, then link_up=path_en=1 one cycle later.
- Lane0 COM,COM,COM,8'h55,COM,COM,COM,COM -> lock occurs only on the 8th strobe; the 8'h55 resets sync_cnt.
- Linked, lane1 sends 8'hA5 with no err -> data_stb=10, data_byte[15:8]=A5 next cycle; IDL or COM -> data_stb stays 0.
- Linked, lane0 err,err,data,err,err -> stays locked; then a 3rd consecutive err -> lane_locked=10, link_up=0 same cycle, loss_cnt=1.
- Simultaneous 3-error run on both lanes -> loss_cnt +2. Preload to 254, repeat -> loss_cnt=255 and holds.
- Linked, retrain pulse -> lane_locked=00, link_up=0 next cycle, loss_cnt unchanged; strobes during retrain=1 do not advance sync_cnt; relock requires a full 4-COM sequence.

Source files
------------

// File: rtl/phy_rx_link_ctrl_if.sv
// Lane-side bus of the PHY receive link controller: deframer bytes and strobes in,
// per-lane lock status, link status and registered payload strobes out.
interface phy_rx_link_ctrl_if #(
    parameter int unsigned NUM_LANES = 2
);
    logic [8*NUM_LANES-1:0] lane_byte;
    logic [NUM_LANES-1:0]   lane_stb;
    logic [NUM_LANES-1:0]   lane_err;
    logic [NUM_LANES-1:0]   lane_locked;
    logic                   link_up;
    logic                   path_en;
    logic [NUM_LANES-1:0]   data_stb;
    logic [8*NUM_LANES-1:0] data_byte;
    logic [7:0]             loss_cnt;

    modport master (
        output lane_byte, lane_stb, lane_err,
        input  lane_locked, link_up, path_en, data_stb, data_byte, loss_cnt
    );

    modport slave (
        input  lane_byte, lane_stb, lane_err,
        output lane_locked, link_up, path_en, data_stb, data_byte, loss_cnt
    );
endinterface

// File: rtl/phy_rx_link_ctrl.sv
// Link bring-up for the two-lane PHY receive path: per-lane COM-hunting lock FSMs,
// a global link FSM gating the 8-to-32 converters, and a saturating lock-loss counter.
module phy_rx_link_ctrl #(
    parameter int unsigned NUM_LANES  = 2,
    parameter logic [7:0]  COM        = 8'hBC,
    parameter logic [7:0]  IDL        = 8'h7C,
    parameter int unsigned SYNC_COUNT = 4,
    parameter int unsigned LOSS_LIMIT = 3
) (
    input logic               clk,
    input logic               reset,
    input logic               retrain,
    phy_rx_link_ctrl_if.slave bus
);
    typedef enum logic {LANE_HUNT, LANE_LOCKED} lane_state_e;
    typedef enum logic {LINK_DOWN, LINK_UP}     link_state_e;

    localparam logic [3:0] SYNC_LAST = 4'(SYNC_COUNT - 1);
    localparam logic [3:0] LOSS_LAST = 4'(LOSS_LIMIT - 1);

    lane_state_e            lane_state_q [NUM_LANES];
    lane_state_e            lane_state_d [NUM_LANES];
    logic [3:0]             sync_cnt_q   [NUM_LANES];
    logic [3:0]             sync_cnt_d   [NUM_LANES];
    logic [3:0]             err_cnt_q    [NUM_LANES];
    logic [3:0]             err_cnt_d    [NUM_LANES];
    link_state_e            link_state_q, link_state_d;
    logic [NUM_LANES-1:0]   data_stb_q, data_stb_d;
    logic [8*NUM_LANES-1:0] data_byte_q, data_byte_d;
    logic [7:0]             loss_cnt_q, loss_cnt_d;

    logic [NUM_LANES-1:0]   is_com;
    logic [NUM_LANES-1:0]   is_idl;
    logic [NUM_LANES-1:0]   loss_evt;
    logic [NUM_LANES-1:0]   locked_now;
    logic [NUM_LANES-1:0]   locked_next;
    logic [8:0]             loss_sum;

    // Per-lane lock FSMs: state only moves on that lane's strobe, retrain overrides.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path leaves it
        // unassigned; otherwise synthesis infers a latch to hold the old value.
        is_com   = '0;
        is_idl   = '0;
        loss_evt = '0;
        data_stb_d  = '0;
        data_byte_d = bus.lane_byte;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_state_d[i] = lane_state_q[i];
            sync_cnt_d[i]   = sync_cnt_q[i];
            err_cnt_d[i]    = err_cnt_q[i];
            is_com[i] = (bus.lane_byte[8*i +: 8] == COM);
            is_idl[i] = (bus.lane_byte[8*i +: 8] == IDL);

            if (retrain) begin
                lane_state_d[i] = LANE_HUNT;
                sync_cnt_d[i]   = '0;
                err_cnt_d[i]    = '0;
            end else if (bus.lane_stb[i]) begin
                case (lane_state_q[i])
                    LANE_HUNT: begin
                        if (is_com[i] && !bus.lane_err[i]) begin
                            if (sync_cnt_q[i] == SYNC_LAST) begin
                                lane_state_d[i] = LANE_LOCKED;
                                sync_cnt_d[i]   = '0;
                            end else begin
                                sync_cnt_d[i] = sync_cnt_q[i] + 4'd1;
                            end
                        end else begin
                            sync_cnt_d[i] = '0;
                        end
                    end
                    LANE_LOCKED: begin
                        if (bus.lane_err[i]) begin
                            if (err_cnt_q[i] == LOSS_LAST) begin
                                lane_state_d[i] = LANE_HUNT;
                                err_cnt_d[i]    = '0;
                                loss_evt[i]     = 1'b1;
                            end else begin
                                err_cnt_d[i] = err_cnt_q[i] + 4'd1;
                            end
                        end else begin
                            err_cnt_d[i]  = '0;
                            data_stb_d[i] = !is_com[i] && !is_idl[i];
                        end
                    end
                    default: lane_state_d[i] = LANE_HUNT;
                endcase
            end
        end
    end

    // Link goes down on the same edge any lane drops; comes up one cycle after all are locked.
    always_comb begin
        locked_now  = '0;
        locked_next = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            locked_now[i]  = (lane_state_q[i] == LANE_LOCKED);
            locked_next[i] = (lane_state_d[i] == LANE_LOCKED);
        end

        link_state_d = link_state_q;
        if (!(&locked_next)) begin
            link_state_d = LINK_DOWN;
        end else if (link_state_q == LINK_DOWN && (&locked_now)) begin
            link_state_d = LINK_UP;
        end
    end

    always_comb begin
        loss_sum = {1'b0, loss_cnt_q};
        for (int i = 0; i < NUM_LANES; i++) begin
            loss_sum = loss_sum + {8'd0, loss_evt[i]};
        end
        loss_cnt_d = loss_sum[8] ? 8'hFF : loss_sum[7:0];
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples the
        // pre-edge values; blocking here would create order-dependent simulation races.
        if (reset) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_state_q[i] <= LANE_HUNT;
                sync_cnt_q[i]   <= '0;
                err_cnt_q[i]    <= '0;
            end
            link_state_q <= LINK_DOWN;
            data_stb_q   <= '0;
            data_byte_q  <= '0;
            loss_cnt_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_state_q[i] <= lane_state_d[i];
                sync_cnt_q[i]   <= sync_cnt_d[i];
                err_cnt_q[i]    <= err_cnt_d[i];
            end
            link_state_q <= link_state_d;
            data_stb_q   <= data_stb_d;
            data_byte_q  <= data_byte_d;
            loss_cnt_q   <= loss_cnt_d;
        end
    end

    assign bus.lane_locked = locked_now;
    assign bus.link_up     = (link_state_q == LINK_UP);
    assign bus.path_en     = (link_state_q == LINK_UP);
    assign bus.data_stb    = data_stb_q;
    assign bus.data_byte   = data_byte_q;
    assign bus.loss_cnt    = loss_cnt_q;
endmodule

// File: tb/tb_phy_rx_link_ctrl.sv
// Self-checking bench for phy_rx_link_ctrl: directed vector table, multi-cycle
// corner sequences, then randomized traffic against a behavioural lane/link model.
module tb_phy_rx_link_ctrl;
    localparam logic [7:0] COM        = 8'hBC;
    localparam logic [7:0] IDL        = 8'h7C;
    localparam int         SYNC_COUNT = 4;
    localparam int         LOSS_LIMIT = 3;

    logic clk;
    logic reset;
    logic retrain;

    phy_rx_link_ctrl_if bus ();

    phy_rx_link_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .retrain (retrain),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: lock status, consecutive COM/error runs, link flag, loss count.
    bit [1:0]  m_locked;
    int        m_com_run [2];
    int        m_err_run [2];
    bit        m_link;
    int        m_loss;
    bit [1:0]  m_dstb;
    bit [15:0] m_dbyte;

    typedef struct {
        bit        r;
        bit [1:0]  stb;
        bit [1:0]  err;
        bit [15:0] lb;
        bit [1:0]  exp_locked;
        bit        exp_link;
        bit [1:0]  exp_dstb;
        bit [7:0]  exp_loss;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = '0;
        m_link   = 1'b0;
        m_loss   = 0;
        m_dstb   = '0;
        m_dbyte  = '0;
        for (int l = 0; l < 2; l++) begin
            m_com_run[l] = 0;
            m_err_run[l] = 0;
        end
    endtask

    task automatic model_step(input bit r, input bit [1:0] stb, input bit [1:0] err,
                              input bit [15:0] lb);
        bit       all_before;
        int       losses;
        bit [7:0] b;
        all_before = (m_locked == 2'b11);
        losses     = 0;
        m_dstb     = '0;
        for (int l = 0; l < 2; l++) begin
            b = lb[8*l +: 8];
            if (r) begin
                m_locked[l]  = 1'b0;
                m_com_run[l] = 0;
                m_err_run[l] = 0;
            end else if (stb[l]) begin
                if (!m_locked[l]) begin
                    m_com_run[l] = (b == COM && !err[l]) ? m_com_run[l] + 1 : 0;
                    if (m_com_run[l] == SYNC_COUNT) begin
                        m_locked[l]  = 1'b1;
                        m_com_run[l] = 0;
                    end
                end else if (err[l]) begin
                    m_err_run[l]++;
                    if (m_err_run[l] == LOSS_LIMIT) begin
                        m_locked[l]  = 1'b0;
                        m_err_run[l] = 0;
                        losses++;
                    end
                end else begin
                    m_err_run[l] = 0;
                    m_dstb[l]    = (b != COM) && (b != IDL);
                end
            end
        end
        m_link  = (m_locked == 2'b11) && (m_link || all_before);
        m_loss  = (m_loss + losses > 255) ? 255 : m_loss + losses;
        m_dbyte = lb;
    endtask

    task automatic check_model();
        check("model_locked", 16'(bus.lane_locked), 16'(m_locked));
        check("model_link_up", 16'(bus.link_up), 16'(m_link));
        check("model_path_en", 16'(bus.path_en), 16'(m_link));
        check("model_data_stb", 16'(bus.data_stb), 16'(m_dstb));
        check("model_loss_cnt", 16'(bus.loss_cnt), 16'(m_loss));
        for (int l = 0; l < 2; l++) begin
            if (m_dstb[l]) check($sformatf("model_data_byte%0d", l),
                                 16'(bus.data_byte[8*l +: 8]), 16'(m_dbyte[8*l +: 8]));
        end
    endtask

    task automatic step(input bit r, input bit [1:0] stb, input bit [1:0] err,
                        input bit [15:0] lb);
        @(negedge clk);
        retrain       = r;
        bus.lane_stb  = stb;
        bus.lane_err  = err;
        bus.lane_byte = lb;
        @(posedge clk);
        #1;
        model_step(r, stb, err, lb);
        check_model();
    endtask

    task automatic com_burst(input bit [1:0] lanes, input int n);
        for (int k = 0; k < n; k++) step(1'b0, lanes, 2'b00, {COM, COM});
    endtask

    task automatic err_burst(input bit [1:0] lanes, input int n);
        for (int k = 0; k < n; k++) step(1'b0, lanes, lanes, 16'h0F0F);
    endtask

    task automatic idle();
        step(1'b0, 2'b00, 2'b00, 16'h0000);
    endtask

    task automatic check_outs(input string tag, input bit [1:0] locked, input bit link,
                              input bit [7:0] loss);
        check({tag, "_locked"}, 16'(bus.lane_locked), 16'(locked));
        check({tag, "_link_up"}, 16'(bus.link_up), 16'(link));
        check({tag, "_path_en"}, 16'(bus.path_en), 16'(link));
        check({tag, "_loss_cnt"}, 16'(bus.loss_cnt), 16'(loss));
    endtask

    // Reset is held with retrain and COM strobes active to show it wins over both.
    task automatic do_reset(input string tag);
        @(negedge clk);
        reset         = 1'b1;
        retrain       = 1'b1;
        bus.lane_stb  = 2'b11;
        bus.lane_err  = 2'b00;
        bus.lane_byte = {COM, COM};
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_outs(tag, 2'b00, 1'b0, 8'd0);
        check({tag, "_data_stb"}, 16'(bus.data_stb), 16'd0);
        check({tag, "_data_byte"}, bus.data_byte, 16'd0);
        @(negedge clk);
        reset        = 1'b0;
        retrain      = 1'b0;
        bus.lane_stb = 2'b00;
    endtask

    initial begin
        bit [1:0]  r_stb;
        bit [1:0]  r_err;
        bit [15:0] r_lb;
        bit        r_r;
        int        err_pct;
        int        pick;
        int        guard;

        reset         = 1'b1;
        retrain       = 1'b0;
        bus.lane_stb  = '0;
        bus.lane_err  = '0;
        bus.lane_byte = '0;
        model_reset();

        // Bring-up, then payload filtering on a linked pair.
        vecs[0]  = '{1'b0, 2'b01, 2'b00, 16'h00BC, 2'b00, 1'b0, 2'b00, 8'd0};
        vecs[1]  = '{1'b0, 2'b01, 2'b00, 16'h00BC, 2'b00, 1'b0, 2'b00, 8'd0};
        vecs[2]  = '{1'b0, 2'b01, 2'b00, 16'h00BC, 2'b00, 1'b0, 2'b00, 8'd0};
        vecs[3]  = '{1'b0, 2'b01, 2'b00, 16'h00BC, 2'b01, 1'b0, 2'b00, 8'd0};
        vecs[4]  = '{1'b0, 2'b10, 2'b00, 16'hBC00, 2'b01, 1'b0, 2'b00, 8'd0};
        vecs[5]  = '{1'b0, 2'b10, 2'b00, 16'hBC00, 2'b01, 1'b0, 2'b00, 8'd0};
        vecs[6]  = '{1'b0, 2'b10, 2'b00, 16'hBC00, 2'b01, 1'b0, 2'b00, 8'd0};
        vecs[7]  = '{1'b0, 2'b10, 2'b00, 16'hBC00, 2'b11, 1'b0, 2'b00, 8'd0};
        vecs[8]  = '{1'b0, 2'b00, 2'b00, 16'h0000, 2'b11, 1'b1, 2'b00, 8'd0};
        vecs[9]  = '{1'b0, 2'b10, 2'b00, 16'hA500, 2'b11, 1'b1, 2'b10, 8'd0};
        vecs[10] = '{1'b0, 2'b10, 2'b00, 16'h7C00, 2'b11, 1'b1, 2'b00, 8'd0};
        vecs[11] = '{1'b0, 2'b10, 2'b00, 16'hBC00, 2'b11, 1'b1, 2'b00, 8'd0};
        vecs[12] = '{1'b0, 2'b11, 2'b00, 16'h1234, 2'b11, 1'b1, 2'b11, 8'd0};
        vecs[13] = '{1'b0, 2'b01, 2'b01, 16'h0034, 2'b11, 1'b1, 2'b00, 8'd0};
        vecs[14] = '{1'b0, 2'b01, 2'b00, 16'h0055, 2'b11, 1'b1, 2'b01, 8'd0};

        do_reset("reset_initial");

        for (int k = 0; k < 15; k++) begin
            step(vecs[k].r, vecs[k].stb, vecs[k].err, vecs[k].lb);
            check($sformatf("vec%0d_locked", k), 16'(bus.lane_locked), 16'(vecs[k].exp_locked));
            check($sformatf("vec%0d_link_up", k), 16'(bus.link_up), 16'(vecs[k].exp_link));
            check($sformatf("vec%0d_path_en", k), 16'(bus.path_en), 16'(vecs[k].exp_link));
            check($sformatf("vec%0d_data_stb", k), 16'(bus.data_stb), 16'(vecs[k].exp_dstb));
            check($sformatf("vec%0d_loss_cnt", k), 16'(bus.loss_cnt), 16'(vecs[k].exp_loss));
            for (int l = 0; l < 2; l++) begin
                if (vecs[k].exp_dstb[l]) check($sformatf("vec%0d_data_byte%0d", k, l),
                    16'(bus.data_byte[8*l +: 8]), 16'(vecs[k].lb[8*l +: 8]));
            end
        end

        // Errors must be consecutive: a clean data byte breaks the run.
        err_burst(2'b01, 2);
        step(1'b0, 2'b01, 2'b00, 16'h0055);
        err_burst(2'b01, 2);
        check_outs("err_run_broken", 2'b11, 1'b1, 8'd0);
        err_burst(2'b01, 1);
        check_outs("lane0_loss", 2'b10, 1'b0, 8'd1);

        // Relock lane0, then lose both lanes on the same edge.
        com_burst(2'b01, SYNC_COUNT);
        check_outs("relock_lane0", 2'b11, 1'b0, 8'd1);
        idle();
        check_outs("relink", 2'b11, 1'b1, 8'd1);
        err_burst(2'b11, LOSS_LIMIT - 1);
        check_outs("dual_err_pending", 2'b11, 1'b1, 8'd1);
        err_burst(2'b11, 1);
        check_outs("dual_loss", 2'b00, 1'b0, 8'd3);

        // A non-COM byte inside the hunt restarts the COM count.
        com_burst(2'b01, 3);
        step(1'b0, 2'b01, 2'b00, 16'h0055);
        com_burst(2'b01, 3);
        check_outs("hunt_restart_7th", 2'b00, 1'b0, 8'd3);
        com_burst(2'b01, 1);
        check_outs("hunt_restart_8th", 2'b01, 1'b0, 8'd3);

        // Retrain drops everything next edge, ignores strobes while high, keeps loss_cnt.
        com_burst(2'b10, SYNC_COUNT);
        idle();
        check_outs("pre_retrain", 2'b11, 1'b1, 8'd3);
        step(1'b1, 2'b00, 2'b00, 16'h0000);
        check_outs("retrain_pulse", 2'b00, 1'b0, 8'd3);
        for (int k = 0; k < 3; k++) step(1'b1, 2'b11, 2'b00, {COM, COM});
        check_outs("retrain_held", 2'b00, 1'b0, 8'd3);
        com_burst(2'b11, SYNC_COUNT - 1);
        check_outs("post_retrain_3com", 2'b00, 1'b0, 8'd3);
        com_burst(2'b11, 1);
        check_outs("post_retrain_4com", 2'b11, 1'b0, 8'd3);
        idle();
        check_outs("post_retrain_link", 2'b11, 1'b1, 8'd3);

        // Drive loss_cnt up to 254, then show saturation at 255.
        err_burst(2'b01, LOSS_LIMIT);
        guard = 0;
        while (m_loss < 254 && guard < 200) begin
            com_burst(2'b11, SYNC_COUNT);
            err_burst(2'b11, LOSS_LIMIT);
            guard++;
        end
        check("loss_preload_254", 16'(bus.loss_cnt), 16'd254);
        com_burst(2'b11, SYNC_COUNT);
        err_burst(2'b11, LOSS_LIMIT);
        check("loss_saturate_255", 16'(bus.loss_cnt), 16'd255);
        com_burst(2'b11, SYNC_COUNT);
        err_burst(2'b11, LOSS_LIMIT);
        check("loss_hold_255", 16'(bus.loss_cnt), 16'd255);

        // Reset mid-lock clears loss_cnt too.
        com_burst(2'b11, SYNC_COUNT);
        idle();
        check_outs("pre_reset_linked", 2'b11, 1'b1, 8'd255);
        do_reset("reset_mid_lock");

        // Randomized traffic, alternating low- and high-error phases.
        for (int blk = 0; blk < 6; blk++) begin
            err_pct = (blk % 2 == 1) ? 35 : 4;
            for (int n = 0; n < 500; n++) begin
                for (int l = 0; l < 2; l++) begin
                    r_stb[l] = ($urandom_range(0, 99) < 80);
                    r_err[l] = ($urandom_range(0, 99) < err_pct);
                    pick     = $urandom_range(0, 9);
                    r_lb[8*l +: 8] = (pick < 5) ? COM : (pick < 7) ? IDL : 8'($urandom);
                end
                r_r = ($urandom_range(0, 199) == 0);
                step(r_r, r_stb, r_err, r_lb);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
